risc_v_div_seq: RTL and testbench

- Multi-cycle sequencer for the RV32M division group (DIV, DIVU, REM, REMU), running one restoring-division iteration per clock.
- Replaces the single-cycle combinational divide in the lite ALU when EXTENSION_MDIV is enabled.
- The core issues an operation with a start pulse and stalls on busy.
- Handles the RISC-V special cases directly, and caches the last quotient/remainder pair so that a DIV followed by a REM on the same operands completes in one cycle.

---
 rtl/risc_v_div_seq_pkg.sv | 19 +
 rtl/risc_v_div_step.sv | 20 ++
 rtl/risc_v_div_seq.sv | 134 +++++++++++++
 tb/tb_risc_v_div_seq.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/risc_v_div_seq_pkg.sv
// Shared definitions for the RV32M division sequencer: funct3 codes,
// FSM state encoding and iteration count.
package risc_v_div_seq_pkg;

  localparam logic [2:0] F3_DIV  = 3'd4;
  localparam logic [2:0] F3_DIVU = 3'd5;
  localparam logic [2:0] F3_REM  = 3'd6;
  localparam logic [2:0] F3_REMU = 3'd7;

  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/risc_v_div_step.sv
// One restoring-division iteration, purely combinational; 0 cycles latency.
// No flow control -- the sequencer decides when the result is registered.
module risc_v_div_step (
  input  logic [31:0] r,
  input  logic [31:0] divisor,
  input  logic        dvd_msb,
  output logic [31:0] r_nxt,
  output logic        q_bit
);

  logic [32:0] shifted;
  logic [31:0] r_sub;

  // The compare needs all 33 bits; the difference always fits in 32 because r < divisor.
  assign shifted = {r, dvd_msb};
  assign q_bit   = (shifted >= {1'b0, divisor});
  assign r_sub   = shifted[31:0] - divisor;
  assign r_nxt   = q_bit ? r_sub : shifted[31:0];

endmodule

// File: rtl/risc_v_div_seq.sv
// RV32M DIV/DIVU/REM/REMU sequencer, one restoring iteration per clock.
// Latency 34 cycles (1 for special operands / cache hit); core stalls on busy.
module risc_v_div_seq
  import risc_v_div_seq_pkg::*;
#(
  parameter string RESULT_CACHE = "TRUE",
  parameter string FAST_SPECIAL = "TRUE"
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] rd
);

  localparam bit USE_CACHE = (RESULT_CACHE == "TRUE");
  localparam bit USE_FAST  = (FAST_SPECIAL == "TRUE");

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [31:0] dvd;       // dividend shifting out, quotient shifting in
  logic [31:0] rem_r;
  logic [31:0] dsr;
  logic        q_neg, r_neg, want_rem;

  logic        c_vld, c_signed;
  logic [31:0] c_rs1, c_rs2, c_q, c_r;

  logic        accept, in_signed, in_rem, special, hit;
  logic        div_zero, ovf;
  logic [31:0] r_nxt, q_fix, r_fix;
  logic        q_bit;

  assign in_signed = (funct3 == F3_DIV) || (funct3 == F3_REM);
  assign in_rem    = (funct3 == F3_REM) || (funct3 == F3_REMU);
  assign div_zero  = (rs2 == 32'd0);
  assign ovf       = in_signed && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
  assign special   = USE_FAST && (div_zero || ovf);
  assign hit       = USE_CACHE && c_vld && (c_rs1 == rs1) && (c_rs2 == rs2)
                     && (c_signed == in_signed);
  assign q_fix     = q_neg ? (32'd0 - dvd) : dvd;
  assign r_fix     = r_neg ? (32'd0 - rem_r) : rem_r;

  risc_v_div_step u_step (
    .r       (rem_r),
    .divisor (dsr),
    .dvd_msb (dvd[31]),
    .r_nxt   (r_nxt),
    .q_bit   (q_bit)
  );

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = start && !flush && (funct3 >= F3_DIV)
                && ((state == ST_IDLE) || (state == ST_DONE));
    case (state)
      ST_IDLE:  if (accept) state_nxt = (special || hit) ? ST_DONE : ST_CALC;
      ST_CALC: begin
        busy = 1'b1;
        if (cnt == 6'(DIV_ITERS - 1)) state_nxt = ST_FIXUP;
      end
      ST_FIXUP: begin
        busy      = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = accept ? ((special || hit) ? ST_DONE : ST_CALC) : ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      dvd      <= '0;
      rem_r    <= '0;
      dsr      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      want_rem <= 1'b0;
      rd       <= '0;
      c_vld    <= 1'b0;
      c_signed <= 1'b0;
      c_rs1    <= '0;
      c_rs2    <= '0;
      c_q      <= '0;
      c_r      <= '0;
    end else if (accept) begin
      cnt      <= '0;
      rem_r    <= '0;
      dvd      <= (in_signed && rs1[31]) ? (32'd0 - rs1) : rs1;
      dsr      <= (in_signed && rs2[31]) ? (32'd0 - rs2) : rs2;
      q_neg    <= in_signed && (rs1[31] ^ rs2[31]) && !div_zero;
      r_neg    <= in_signed && rs1[31];
      want_rem <= in_rem;
      c_signed <= in_signed;
      c_rs1    <= rs1;
      c_rs2    <= rs2;
      if (special) begin
        if (div_zero) rd <= in_rem ? rs1 : 32'hFFFF_FFFF;
        else          rd <= in_rem ? 32'd0 : 32'h8000_0000;
      end else if (hit) begin
        rd <= in_rem ? c_r : c_q;
      end
      // A miss overwrites the tag fields, so drop the entry until FIXUP refills it.
      if (!special && !hit) c_vld <= 1'b0;
    end else if (!flush && state == ST_CALC) begin
      dvd   <= {dvd[30:0], q_bit};
      rem_r <= r_nxt;
      cnt   <= cnt + 6'd1;
    end else if (!flush && state == ST_FIXUP) begin
      c_vld <= 1'b1;
      c_q   <= q_fix;
      c_r   <= r_fix;
      rd    <= want_rem ? r_fix : q_fix;
    end
  end

endmodule

// File: tb/tb_risc_v_div_seq.sv
// Directed bench for risc_v_div_seq: latency, special cases, cache hits,
// flush, start-while-busy, back-to-back issue and mid-operation reset.
module tb_risc_v_div_seq;

  logic        clk = 1'b0;
  logic        rst_n, start, flush, busy, done;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2, rd;
  int          errors = 0;
  int          checks = 0;
  int          lat, bcnt, ndone;
  logic [31:0] res;

  risc_v_div_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .flush(flush), .busy(busy), .done(done), .rd(rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue at the current negedge (cycle 0); return the cycle of done and busy count.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int l, output int bc, output logic [31:0] r);
    start = 1'b1; funct3 = f; rs1 = a; rs2 = b;
    l = -1; bc = 0; r = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) bc++;
      if (done) begin
        l = k; r = rd;
        break;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_rd", rd, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(3'd5, 32'd100, 32'd7, lat, bcnt, res);
    chk("divu_lat", lat, 34);
    chk("divu_busy_cycles", bcnt, 33);
    chk("divu_rd", res, 32'd14);
    run_op(3'd7, 32'd100, 32'd7, lat, bcnt, res);
    chk("remu_hit_lat", lat, 1);
    chk("remu_hit_busy", bcnt, 0);
    chk("remu_hit_rd", res, 32'd2);

    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, lat, bcnt, res);
    chk("div_neg_lat", lat, 34);
    chk("div_neg_rd", res, 32'hFFFF_FFFD);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, lat, bcnt, res);
    chk("rem_neg_hit_lat", lat, 1);
    chk("rem_neg_rd", res, 32'hFFFF_FFFF);

    run_op(3'd4, 32'h1234, 32'd0, lat, bcnt, res);
    chk("div0_lat", lat, 1);
    chk("div0_rd", res, 32'hFFFF_FFFF);
    run_op(3'd7, 32'h1234, 32'd0, lat, bcnt, res);
    chk("remu0_lat", lat, 1);
    chk("remu0_rd", res, 32'h1234);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt, res);
    chk("ovf_div_lat", lat, 1);
    chk("ovf_div_rd", res, 32'h8000_0000);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt, res);
    chk("ovf_rem_lat", lat, 1);
    chk("ovf_rem_rd", res, 32'd0);

    // funct3 below DIV must not start anything
    @(negedge clk);
    start = 1'b1; funct3 = 3'd3; rs1 = 32'd50; rs2 = 32'd5;
    @(negedge clk);
    start = 1'b0;
    chk("f3low_busy", 32'(busy), 32'd0);
    chk("f3low_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("f3low_done2", 32'(done), 32'd0);

    // flush in cycle 10 of DIVU 1000/3
    start = 1'b1; funct3 = 3'd5; rs1 = 32'd1000; rs2 = 32'd3;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_c11", 32'(busy), 32'd0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("flush_no_done", ndone, 0);
    run_op(3'd5, 32'd1000, 32'd3, lat, bcnt, res);
    chk("reissue_lat", lat, 34);
    chk("reissue_rd", res, 32'd333);

    // start held during CALC with other operands is ignored
    start = 1'b1; funct3 = 3'd5; rs1 = 32'd200; rs2 = 32'd9;
    lat = -1; res = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k < 10) begin
        rs1 = 32'd50; rs2 = 32'd5;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = k; res = rd;
        break;
      end
    end
    chk("hold_start_lat", lat, 34);
    chk("hold_start_rd", res, 32'd22);

    // issued in the DONE cycle of the previous op
    run_op(3'd5, 32'd1000, 32'd7, lat, bcnt, res);
    chk("b2b_lat", lat, 34);
    chk("b2b_rd", res, 32'd142);

    run_op(3'd4, 32'd100, 32'd7, lat, bcnt, res);
    chk("div_pre_reset_rd", res, 32'd14);

    // asynchronous reset in cycle 20 of a long op
    start = 1'b1; funct3 = 3'd4; rs1 = 32'd5000; rs2 = 32'd3;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_rd", rd, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(3'd6, 32'd100, 32'd7, lat, bcnt, res);
    chk("post_reset_rem_lat", lat, 34);
    chk("post_reset_rem_rd", res, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
